pipe_stage_skid: RTL and testbench

//   Parametrised pipeline stage register for the CPU datapath (EX/MEM, MEM/WB, ...).

---
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with control/data split, ready/valid backpressure and flush.
// SKID=1 adds a second entry so in_ready can be registered; SKID=0 is a single register.
module pipe_stage_skid #(
  parameter int unsigned         CTRL_W   = 5,
  parameter int unsigned         DATA_W   = 64,
  parameter logic [CTRL_W-1:0]   CTRL_RST = '0,
  parameter bit                  SKID     = 1'b1,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [CTRL_W-1:0] m_ctrl_q;
  logic [DATA_W-1:0] m_data_q;
  logic [CTRL_W-1:0] s_ctrl_q;
  logic [DATA_W-1:0] s_data_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic accept;
  logic retire;

  // Without the skid entry the stage can only take a beat if its one slot drains this cycle.
  assign in_ready = SKID ? in_ready_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      m_ctrl_q    <= CTRL_RST;
      m_data_q    <= '0;
      s_ctrl_q    <= CTRL_RST;
      s_data_q    <= '0;
    end else if (flush) begin
      // Any accepted beat is dropped; data fields are left as they were.
      state_q     <= StEmpty;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      m_ctrl_q    <= CTRL_RST;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q     <= StOne;
            out_valid_q <= 1'b1;
            m_ctrl_q    <= in_ctrl;
            m_data_q    <= in_data;
          end
        end
        StOne: begin
          if (accept && retire) begin
            m_ctrl_q <= in_ctrl;
            m_data_q <= in_data;
          end else if (accept) begin
            state_q    <= StTwo;
            in_ready_q <= 1'b0;
            s_ctrl_q   <= in_ctrl;
            s_data_q   <= in_data;
          end else if (retire) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            m_ctrl_q    <= CTRL_RST;
          end
        end
        StTwo: begin
          if (retire) begin
            state_q    <= StOne;
            in_ready_q <= 1'b1;
            m_ctrl_q   <= s_ctrl_q;
            m_data_q   <= s_data_q;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          m_ctrl_q    <= CTRL_RST;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  bubble_ctrl_a: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (out_ctrl == CTRL_RST));

  full_not_ready_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == StTwo) |-> !in_ready);

  valid_matches_state_a: assert property (@(posedge clk) disable iff (rst)
    out_valid == (state_q != StEmpty));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a skid instance (SKID=1) and a single-register
// instance (SKID=0, CNT_W=4) driven with directed vectors.
module tb_pipe_stage_skid;

  localparam int unsigned CW = 5;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [15:0]   a_stall_cnt;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [3:0]    b_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW+DW-1:0] qa[$];
  logic [CW+DW-1:0] qb[$];

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(5'h00), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(5'h00), .SKID(1'b0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop on retire, drop on flush/reset, push on accept (after the pop).
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_unexpected_beat: got ctrl %0h data %0h, none expected",
                   a_out_ctrl, a_out_data);
        end else begin
          check("a_beat", 128'({a_out_ctrl, a_out_data}), 128'(qa.pop_front()));
        end
      end else if (!a_out_valid) begin
        check("a_bubble_ctrl", 128'(a_out_ctrl), 128'(5'h00));
      end
      if (a_flush) qa.delete();
      else if (a_in_valid && a_in_ready) qa.push_back({a_in_ctrl, a_in_data});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected_beat: got ctrl %0h data %0h, none expected",
                   b_out_ctrl, b_out_data);
        end else begin
          check("b_beat", 128'({b_out_ctrl, b_out_data}), 128'(qb.pop_front()));
        end
      end else if (!b_out_valid) begin
        check("b_bubble_ctrl", 128'(b_out_ctrl), 128'(5'h00));
      end
      if (b_flush) qb.delete();
      else if (b_in_valid && b_in_ready) qb.push_back({b_in_ctrl, b_in_data});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_ctrl = '0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_ctrl = '0; b_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
    check("rst_out_ctrl", 128'(a_out_ctrl), 128'(5'h00));
    check("rst_out_data", 128'(a_out_data), 128'(64'h0));
    check("rst_in_ready", 128'(a_in_ready), 128'(1'b1));
    check("rst_stall_cnt", 128'(a_stall_cnt), 128'(16'h0));
    check("rst_b_in_ready", 128'(b_in_ready), 128'(1'b1));

    // Streaming 1..8 with out_ready held high
    tick();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_ctrl  = CW'(i);
      a_in_data  = DW'(i);
      @(negedge clk);
      check("stream_in_ready", 128'(a_in_ready), 128'(1'b1));
      if (i > 1) begin
        check("stream_out_valid", 128'(a_out_valid), 128'(1'b1));
        check("stream_out_data", 128'(a_out_data), 128'(i - 1));
      end
      tick();
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_data", 128'(a_out_data), 128'(64'd8));
    tick();
    tick();

    // Backpressure: A into M, B into S, C held upstream
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 5'h01; a_in_data = 64'hA;
    tick();
    a_in_ctrl = 5'h02; a_in_data = 64'hB;
    tick();
    a_in_ctrl = 5'h03; a_in_data = 64'hC;
    @(negedge clk);
    check("bp_in_ready_full", 128'(a_in_ready), 128'(1'b0));
    check("bp_out_data_a", 128'(a_out_data), 128'(64'hA));
    check("bp_stall_1", 128'(a_stall_cnt), 128'(16'd1));
    tick();
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_held", 128'(a_in_ready), 128'(1'b0));
    check("bp_stall_2", 128'(a_stall_cnt), 128'(16'd2));
    tick();
    @(negedge clk);
    check("bp_out_data_b", 128'(a_out_data), 128'(64'hB));
    check("bp_in_ready_back", 128'(a_in_ready), 128'(1'b1));
    tick();
    a_in_valid = 1'b0;
    @(negedge clk);
    check("bp_out_data_c", 128'(a_out_data), 128'(64'hC));
    tick();
    @(negedge clk);
    check("bp_drained", 128'(a_out_valid), 128'(1'b0));
    check("bp_stall_final", 128'(a_stall_cnt), 128'(16'd2));

    // Flush with both entries full of ctrl 1F, plus an incoming beat
    tick();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 5'h1F; a_in_data = 64'hD0;
    tick();
    a_in_data = 64'hE0;
    tick();
    a_in_data = 64'hF0;
    a_flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready_full", 128'(a_in_ready), 128'(1'b0));
    check("fl_out_ctrl_pre", 128'(a_out_ctrl), 128'(5'h1F));
    tick();
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    check("fl_out_valid", 128'(a_out_valid), 128'(1'b0));
    check("fl_out_ctrl", 128'(a_out_ctrl), 128'(5'h00));
    check("fl_in_ready", 128'(a_in_ready), 128'(1'b1));
    check("fl_data_kept", 128'(a_out_data), 128'(64'hD0));
    check("fl_stall_kept", 128'(a_stall_cnt), 128'(16'd4));
    tick();
    a_out_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-transfer discards the held beat
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 5'h02; a_in_data = 64'h77;
    tick();
    a_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_out_valid", 128'(a_out_valid), 128'(1'b0));
    check("mrst_stall", 128'(a_stall_cnt), 128'(16'd0));
    check("mrst_in_ready", 128'(a_in_ready), 128'(1'b1));
    tick();
    a_out_ready = 1'b1;
    repeat (3) tick();

    // SKID=0 streaming
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1;
      b_in_ctrl  = CW'(i + 8);
      b_in_data  = DW'(256 + i);
      @(negedge clk);
      check("b_stream_in_ready", 128'(b_in_ready), 128'(1'b1));
      tick();
    end
    b_in_valid = 1'b0;
    repeat (2) tick();

    // SKID=0 single-cycle stall, combinational in_ready
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = 5'h03; b_in_data = 64'h55;
    @(negedge clk);
    check("b_in_ready_empty", 128'(b_in_ready), 128'(1'b1));
    tick();
    b_in_ctrl = 5'h04; b_in_data = 64'h66;
    @(negedge clk);
    check("b_in_ready_stall", 128'(b_in_ready), 128'(1'b0));
    check("b_held_data", 128'(b_out_data), 128'(64'h55));
    tick();
    b_out_ready = 1'b1;
    #1;
    check("b_in_ready_comb", 128'(b_in_ready), 128'(1'b1));
    tick();
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_second_data", 128'(b_out_data), 128'(64'h66));
    check("b_stall_one", 128'(b_stall_cnt), 128'(4'd1));
    tick();

    // Counter saturation on the 4-bit instance
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = 5'h07; b_in_data = 64'h99;
    tick();
    b_in_valid = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    check("b_stall_sat", 128'(b_stall_cnt), 128'(4'hF));
    check("b_sat_valid", 128'(b_out_valid), 128'(1'b1));
    check("b_sat_data", 128'(b_out_data), 128'(64'h99));
    tick();
    b_out_ready = 1'b1;
    repeat (3) tick();

    @(negedge clk);
    check("a_queue_drained", 128'(qa.size()), 128'(0));
    check("b_queue_drained", 128'(qb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
